// File: rtl/multicycle_alu_if.sv
// multicycle_alu_if: request/response bundle of the execute-stage ALU.
//   start  - request strobe, honoured only while busy = 0
//   op     - 4-bit operation code, sampled with start
//   dataA  - operand A, sampled with start
//   dataB  - operand B (also the value that SRL/SLL shift), sampled with start
//   shamt  - shift amount, sampled with start
//   result - registered result
//   zero   - (result == 0)
//   busy   - high while MULTU/DIVU iterates
//   done   - one-cycle pulse when result (and HI/LO) is valid
// Modports: master drives requests (controller side), slave is the ALU.
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output start, op, dataA, dataB, shamt,
    input  result, zero, busy, done
  );

  modport slave (
    input  start, op, dataA, dataB, shamt,
    output result, zero, busy, done
  );
endinterface

// File: rtl/multicycle_alu.sv
// multicycle_alu: sequential execute-stage ALU.
// Single-cycle logic/arithmetic/compare/shift ops complete one cycle after
// acceptance; MULTU (shift-add) and DIVU (restoring) iterate one bit per
// cycle for WIDTH cycles and then write the internal HI/LO pair.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset (aborts any running operation)
//   bus   - multicycle_alu_if slave modport (start/op/operands in,
//           result/zero/busy/done out)
// WIDTH must be >= 4 and a power of two; SHW is derived from it.
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_alu_if.slave      bus
);

  localparam logic [3:0] OpAnd   = 4'b0000;
  localparam logic [3:0] OpOr    = 4'b0001;
  localparam logic [3:0] OpAdd   = 4'b0010;
  localparam logic [3:0] OpSrl   = 4'b0011;
  localparam logic [3:0] OpSll   = 4'b0100;
  localparam logic [3:0] OpSub   = 4'b0110;
  localparam logic [3:0] OpSlt   = 4'b0111;
  localparam logic [3:0] OpMultu = 4'b1000;
  localparam logic [3:0] OpDivu  = 4'b1001;
  localparam logic [3:0] OpMfhi  = 4'b1010;
  localparam logic [3:0] OpMflo  = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aluState_t;

  aluState_t        stateReg, stateNext;
  logic [SHW-1:0]   countReg;
  logic [WIDTH-1:0] resultReg;
  logic [WIDTH-1:0] hiReg, loReg;
  // Iteration working registers: for MULTU {workHi, workLo} is the partial
  // product with the multiplier shifting out of workLo; for DIVU workHi is the
  // partial remainder and workLo shifts dividend bits out / quotient bits in.
  logic [WIDTH-1:0] workHiReg, workLoReg;
  logic [WIDTH-1:0] operandBReg;
  logic             isDivReg;

  logic             accept;
  logic             isLongOp;
  logic [WIDTH-1:0] quickResult;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divTrial;
  logic [WIDTH-1:0] stepHi, stepLo;

  assign isLongOp = (bus.op == OpMultu) || (bus.op == OpDivu);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next state; DONE accepts a new request exactly like IDLE so that the
  // controller can issue back-to-back.
  always_comb begin
    stateNext = stateReg;
    accept    = 1'b0;
    case (stateReg)
      IDLE, DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          stateNext = isLongOp ? RUN : DONE;
        end else begin
          stateNext = IDLE;
        end
      end
      RUN: begin
        if (countReg == '0) begin
          stateNext = DONE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Single-cycle results, computed straight from the request. MFHI/MFLO read
  // the committed HI/LO, which are already updated in a MULTU/DIVU DONE cycle.
  always_comb begin
    quickResult = '0;
    case (bus.op)
      OpAnd:  quickResult = bus.dataA & bus.dataB;
      OpOr:   quickResult = bus.dataA | bus.dataB;
      OpAdd:  quickResult = bus.dataA + bus.dataB;
      OpSub:  quickResult = bus.dataA - bus.dataB;
      OpSlt:  quickResult = {{(WIDTH-1){1'b0}}, ($signed(bus.dataA) < $signed(bus.dataB))};
      OpSrl:  quickResult = bus.dataB >> bus.shamt;
      OpSll:  quickResult = bus.dataB << bus.shamt;
      OpMfhi: quickResult = hiReg;
      OpMflo: quickResult = loReg;
      default: quickResult = '0;
    endcase
  end

  // One iteration step of either long operation.
  always_comb begin
    // Shift-add: conditionally add B into the upper half, then shift the
    // whole (WIDTH+1)-bit-carry-extended product right by one.
    mulSum   = {1'b0, workHiReg} + (workLoReg[0] ? {1'b0, operandBReg} : '0);
    // Restoring divide: bring the next dividend bit into the remainder and
    // try subtracting B; a set top bit means the trial went negative.
    divTrial = {workHiReg, workLoReg[WIDTH-1]} - {1'b0, operandBReg};
    if (isDivReg) begin
      if (!divTrial[WIDTH]) begin
        stepHi = divTrial[WIDTH-1:0];
        stepLo = {workLoReg[WIDTH-2:0], 1'b1};
      end else begin
        stepHi = {workHiReg[WIDTH-2:0], workLoReg[WIDTH-1]};
        stepLo = {workLoReg[WIDTH-2:0], 1'b0};
      end
    end else begin
      stepHi = mulSum[WIDTH:1];
      stepLo = {mulSum[0], workLoReg[WIDTH-1:1]};
    end
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      countReg    <= '0;
      resultReg   <= '0;
      hiReg       <= '0;
      loReg       <= '0;
      workHiReg   <= '0;
      workLoReg   <= '0;
      operandBReg <= '0;
      isDivReg    <= 1'b0;
    end else if (accept) begin
      if (isLongOp) begin
        workHiReg   <= '0;
        workLoReg   <= bus.dataA;
        operandBReg <= bus.dataB;
        isDivReg    <= (bus.op == OpDivu);
        countReg    <= SHW'(WIDTH - 1);
      end else begin
        resultReg <= quickResult;
      end
    end else if (stateReg == RUN) begin
      workHiReg <= stepHi;
      workLoReg <= stepLo;
      if (countReg == '0) begin
        // Final (WIDTH-th) step commits straight into HI/LO and result.
        hiReg     <= stepHi;
        loReg     <= stepLo;
        resultReg <= stepLo;
      end else begin
        countReg <= countReg - 1'b1;
      end
    end
  end

  assign bus.result = resultReg;
  assign bus.zero   = (resultReg == '0);
  assign bus.busy   = (stateReg == RUN);
  assign bus.done   = (stateReg == DONE);

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: drives a WIDTH=32 and a WIDTH=8 instance with the same
// request stream (operands truncated for the narrow one) and checks both
// against an arithmetic reference model every cycle, plus literal checks on
// the directed scenarios.
module tb_multicycle_alu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [4:0]  shamt;

  int compared   = 0;
  int mismatched = 0;

  multicycle_alu_if #(.WIDTH(32)) bus32 ();
  multicycle_alu_if #(.WIDTH(8))  bus8  ();

  assign bus32.start = start;
  assign bus32.op    = op;
  assign bus32.dataA = dataA;
  assign bus32.dataB = dataB;
  assign bus32.shamt = shamt;
  assign bus8.start  = start;
  assign bus8.op     = op;
  assign bus8.dataA  = dataA[7:0];
  assign bus8.dataB  = dataB[7:0];
  assign bus8.shamt  = shamt[2:0];

  multicycle_alu #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  multicycle_alu #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] mRes [2];
  logic [63:0] mHi  [2];
  logic [63:0] mLo  [2];
  logic [63:0] pRes [2];
  logic [63:0] pHi  [2];
  logic [63:0] pLo  [2];
  int          remain [2];
  bit          mDone  [2];

  function automatic logic [63:0] maskOf(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] quickModel(input int w, input logic [3:0] o,
      input logic [63:0] a, input logic [63:0] b, input int sh,
      input logic [63:0] hi, input logic [63:0] lo);
    logic [63:0] m;
    logic [63:0] sgn;
    m   = maskOf(w);
    sgn = 64'd1 << (w - 1);
    case (o)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return (a + b) & m;
      4'd3:  return b >> sh;
      4'd4:  return (b << sh) & m;
      4'd6:  return (a - b) & m;
      4'd7:  return ((a ^ sgn) < (b ^ sgn)) ? 64'd1 : 64'd0;
      4'd10: return hi;
      4'd11: return lo;
      default: return 64'd0;
    endcase
  endfunction

  task automatic modelStep(input int i);
    int w;
    logic [63:0] m, a, b, prod;
    w = (i == 0) ? 32 : 8;
    m = maskOf(w);
    a = 64'(dataA) & m;
    b = 64'(dataB) & m;
    mDone[i] = 1'b0;
    if (reset) begin
      mRes[i] = 0; mHi[i] = 0; mLo[i] = 0; remain[i] = 0;
    end else if (remain[i] > 0) begin
      remain[i]--;
      if (remain[i] == 0) begin
        mHi[i] = pHi[i]; mLo[i] = pLo[i]; mRes[i] = pRes[i]; mDone[i] = 1'b1;
      end
    end else if (start) begin
      if (op == 4'd8) begin
        prod = a * b;
        pHi[i] = (prod >> w) & m; pLo[i] = prod & m; pRes[i] = pLo[i];
        remain[i] = w;
      end else if (op == 4'd9) begin
        if (b == 0) begin pLo[i] = m; pHi[i] = a; end
        else begin pLo[i] = a / b; pHi[i] = a % b; end
        pRes[i] = pLo[i];
        remain[i] = w;
      end else begin
        mRes[i]  = quickModel(w, op, a, b, int'(shamt) & (w - 1), mHi[i], mLo[i]);
        mDone[i] = 1'b1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mRes[i] = 0; mHi[i] = 0; mLo[i] = 0; remain[i] = 0; mDone[i] = 0;
      pRes[i] = 0; pHi[i] = 0; pLo[i] = 0;
    end
  end

  // Per-cycle compare of both DUTs against the model.
  always @(posedge clk) begin
    modelStep(0);
    modelStep(1);
    #1;
    check("w32 result", 64'(bus32.result), mRes[0]);
    check("w32 zero",   64'(bus32.zero),   64'(mRes[0] == 0));
    check("w32 busy",   64'(bus32.busy),   64'(remain[0] > 0));
    check("w32 done",   64'(bus32.done),   64'(mDone[0]));
    check("w8 result",  64'(bus8.result),  mRes[1]);
    check("w8 zero",    64'(bus8.zero),    64'(mRes[1] == 0));
    check("w8 busy",    64'(bus8.busy),    64'(remain[1] > 0));
    check("w8 done",    64'(bus8.done),    64'(mDone[1]));
  end

  // ---------------- stimulus helpers ----------------
  task automatic setOp(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    start = 1'b1; op = o; dataA = a; dataB = b; shamt = sh;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    @(negedge clk);
    setOp(o, a, b, sh);
  endtask

  // Waits (bounded) for the 32-bit done pulse; also reports when the 8-bit
  // instance first pulsed done. Latency 1 = done in the cycle after acceptance.
  task automatic waitDone(output int lat32, output int lat8);
    lat32 = 0; lat8 = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus8.done && lat8 == 0) lat8 = c;
      if (bus32.done) begin
        lat32 = c;
        break;
      end
    end
    if (lat32 == 0) begin
      compared++;
      mismatched++;
      $display("FAIL done timeout: got no done expected done within 100 cycles");
    end
  endtask

  task automatic runOp(input string name, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh,
                       input logic [31:0] expRes, input int expLat);
    int l32, l8;
    issue(o, a, b, sh);
    waitDone(l32, l8);
    $display("op %s A=0x%08h B=0x%08h sh=%0d -> result=0x%08h lat=%0d", name, a, b, sh,
             bus32.result, l32);
    check({name, " result"}, 64'(bus32.result), 64'(expRes));
    check({name, " latency"}, 64'(l32), 64'(expLat));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int l32, l8, dones;
    reset = 1'b1; start = 1'b0; op = '0; dataA = '0; dataB = '0; shamt = '0;
    repeat (3) @(negedge clk);
    check("reset result", 64'(bus32.result), 64'd0);
    check("reset zero",   64'(bus32.zero),   64'd1);
    check("reset busy",   64'(bus32.busy),   64'd0);
    check("reset done",   64'(bus32.done),   64'd0);
    reset = 1'b0;

    runOp("ADD",  4'd2, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h0, 1);
    check("ADD zero", 64'(bus32.zero), 64'd1);
    runOp("SUB",  4'd6, 32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE, 1);
    runOp("SLT1", 4'd7, 32'h8000_0000, 32'd1, 5'd0, 32'd1, 1);
    runOp("SLT2", 4'd7, 32'd1, 32'h8000_0000, 5'd0, 32'd0, 1);
    runOp("SRL",  4'd3, 32'd0, 32'h8000_0000, 5'd31, 32'd1, 1);
    runOp("SLL",  4'd4, 32'd0, 32'd1, 5'd4, 32'h10, 1);
    runOp("BAD",  4'd13, 32'd9, 32'd9, 5'd0, 32'd0, 1);

    issue(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    waitDone(l32, l8);
    $display("op MULTU 0xffffffff*0xffffffff -> result=0x%08h lat=%0d w8 lat=%0d",
             bus32.result, l32, l8);
    check("MULTU latency", 64'(l32), 64'd33);
    check("MULTU w8 latency", 64'(l8), 64'd9);
    check("MULTU result", 64'(bus32.result), 64'd1);
    runOp("MFHI", 4'd10, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFE, 1);
    check("w8 MFHI", 64'(bus8.result), 64'hFE);
    runOp("MFLO", 4'd11, 32'd0, 32'd0, 5'd0, 32'd1, 1);
    check("w8 MFLO", 64'(bus8.result), 64'h01);

    runOp("DIVU", 4'd9, 32'd100, 32'd7, 5'd0, 32'd14, 33);
    runOp("MFLO", 4'd11, 32'd0, 32'd0, 5'd0, 32'd14, 1);
    runOp("MFHI", 4'd10, 32'd0, 32'd0, 5'd0, 32'd2, 1);
    runOp("DIVU0", 4'd9, 32'h1234, 32'd0, 5'd0, 32'hFFFF_FFFF, 33);
    runOp("MFHI", 4'd10, 32'd0, 32'd0, 5'd0, 32'h1234, 1);

    // Start pulse during MULTU must be ignored; then back-to-back ADD in DONE.
    issue(4'd8, 32'h12345, 32'h6789, 5'd0);
    dones = 0; l32 = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 5) setOp(4'd2, 32'd1000, 32'd1000, 5'd0);
      else begin start = 1'b0; dataA = $urandom; dataB = $urandom; end
      if (bus32.done) begin dones++; l32 = c; break; end
    end
    $display("op MULTU 0x12345*0x6789 with stray start -> result=0x%08h lat=%0d",
             bus32.result, l32);
    check("stray done count", 64'(dones), 64'd1);
    check("stray latency", 64'(l32), 64'd33);
    check("stray product", 64'(bus32.result), 64'd1976345325);
    setOp(4'd2, 32'd3, 32'd4, 5'd0);
    waitDone(l32, l8);
    $display("op ADD in DONE cycle -> result=0x%08h lat=%0d", bus32.result, l32);
    check("b2b latency", 64'(l32), 64'd1);
    check("b2b result", 64'(bus32.result), 64'd7);

    // Reset in the middle of a DIVU.
    issue(4'd9, 32'd1000, 32'd3, 5'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    $display("reset during DIVU -> busy=%0d result=0x%08h", bus32.busy, bus32.result);
    check("abort busy", 64'(bus32.busy), 64'd0);
    check("abort result", 64'(bus32.result), 64'd0);
    check("abort done", 64'(bus32.done), 64'd0);
    runOp("MFHI", 4'd10, 32'd0, 32'd0, 5'd0, 32'd0, 1);
    runOp("MFLO", 4'd11, 32'd0, 32'd0, 5'd0, 32'd0, 1);

    // Random traffic, including starts while busy and illegal op codes.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      op    = 4'($urandom_range(0, 15));
      dataA = $urandom;
      dataB = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      shamt = 5'($urandom_range(0, 31));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
